fir_sample_feeder: RTL



---
 rtl/fir_sample_feeder_if.sv | 11 +
 rtl/fir_sample_feeder.sv | 96 +++++++++
 2 files changed

// File: rtl/fir_sample_feeder_if.sv
// fir_sample_feeder_if: AXI-stream sample link from the feeder to the FIR.
//   tdata  : sample, DATA_W bits
//   tvalid : sample valid
//   tready : FIR ready
interface fir_sample_feeder_if #(parameter int DATA_W = 6);
  logic [DATA_W-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master(output tdata, tvalid, input tready);
  modport slave(input tdata, tvalid, output tready);
endinterface

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: synchronises switch samples, edge-detects the strobe into pushes, buffers them in a FIFO for the FIR.
//   clk, reset            : single clock, synchronous active-high reset
//   in_data, in_strobe    : raw asynchronous switch inputs
//   flush                 : empties the FIFO and clears overflow
//   m_axis                : AXI-stream master (tdata/tvalid out, tready in)
//   fifo_count/full       : occupancy 0..DEPTH and full flag
//   overflow              : sticky, a push was dropped
//   FIR_FEEDER_DEBOUNCE_EN: when defined, the strobe is debounced over DEBOUNCE_CYCLES cycles
module fir_sample_feeder #(
  parameter int DATA_W = 6,
  parameter int DEPTH = 8,
  parameter int DEBOUNCE_CYCLES = 16
)(
  input  logic clk,
  input  logic reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic in_strobe,
  input  logic flush,
  fir_sample_feeder_if.master m_axis,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic fifo_full,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("fir_sample_feeder: DEPTH must be a power of 2 >= 2 and DEBOUNCE_CYCLES >= 1");
  end
  logic [DATA_W-1:0] data_sync1, data_sync2;
  logic strobe_sync1, strobe_s, strobe_lvl, strobe_d;
  logic push, pop, wr_en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync1 <= '0;
      data_sync2 <= '0;
      strobe_sync1 <= 1'b0;
      strobe_s <= 1'b0;
      strobe_d <= 1'b0;
    end else begin
      data_sync1 <= in_data;
      data_sync2 <= data_sync1;
      strobe_sync1 <= in_strobe;
      strobe_s <= strobe_sync1;
      strobe_d <= strobe_lvl;
    end
  end
`ifdef FIR_FEEDER_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [DBW-1:0] db_cnt;
  logic db_lvl;
  // The level follows strobe_s only once it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (strobe_s == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= strobe_s;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end
  assign strobe_lvl = db_lvl;
`else
  assign strobe_lvl = strobe_s;
`endif
  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    push = strobe_lvl & ~strobe_d;
    pop = (fifo_count != '0) & m_axis.tready;
    wr_en = push & (~fifo_full | pop) & ~flush;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_sync2;
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
      overflow <= overflow | (push & fifo_full & ~pop);
    end
  end
  assign m_axis.tvalid = fifo_count != '0;
  assign m_axis.tdata = mem[rd_ptr];
  assign fifo_full = fifo_count == CW'(DEPTH);
endmodule
